// File: rtl/up_down_cmd_ctrl_pkg.sv
// Shared encodings for the up/down command front-end and the counter bench.
package up_down_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/up_down_cmd_ctrl_btn_debounce.sv
// Two-flop synchroniser plus counting debouncer for one raw push-button.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          level_dly_q;

  // The Nth consecutive differing sample flips the level directly.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
    end else begin
      sync1_q     <= i_btn;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
    end
  end

  assign o_level = level_q;
  assign o_rise  = level_q & ~level_dly_q;

endmodule

// File: rtl/up_down_cmd_ctrl.sv
// Button front-end: debounced presses become one-hot load/up/down pulses with auto-repeat.
module up_down_cmd_ctrl
  import up_down_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_btn_up,
  input  logic                  i_btn_down,
  input  logic                  i_btn_load,
  input  logic [DATA_WIDTH-1:0] i_sw_value,
  input  logic                  i_high,
  input  logic                  i_low,
  output logic                  o_load,
  output logic                  o_up,
  output logic                  o_down,
  output logic [DATA_WIDTH-1:0] o_in
);

  localparam int unsigned TW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic up_lvl, up_rise, dn_lvl, dn_rise, ld_lvl, ld_rise;
  logic up_evt, dn_evt, ld_evt, conflict, dir_lvl;

  state_e                state_q, state_d;
  dir_e                  dir_q, dir_d;
  logic [TW-1:0]         timer_q, timer_d, timer_inc;
  logic                  load_q, load_d, up_q, up_d, down_q, down_d;
  logic [DATA_WIDTH-1:0] in_q, in_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_up),
    .o_level(up_lvl), .o_rise(up_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_down),
    .o_level(dn_lvl), .o_rise(dn_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_load),
    .o_level(ld_lvl), .o_rise(ld_rise)
  );

  assign up_evt   = up_rise & up_lvl;
  assign dn_evt   = dn_rise & dn_lvl;
  assign ld_evt   = ld_rise & ld_lvl;
  assign conflict = up_lvl & dn_lvl;
  assign dir_lvl  = (dir_q == DIR_UP) ? up_lvl : dn_lvl;

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    timer_d   = timer_q;
    load_d    = 1'b0;
    up_d      = 1'b0;
    down_d    = 1'b0;
    in_d      = in_q;
    timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

    if (ld_evt) begin
      load_d  = 1'b1;
      in_d    = i_sw_value;
      state_d = ST_IDLE;
      timer_d = '0;
    end else if (conflict) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else if (state_q == ST_IDLE || !dir_lvl) begin
      // Releasing the held direction and pressing the other in one cycle starts the new press.
      state_d = ST_IDLE;
      timer_d = '0;
      if (dn_evt) begin
        down_d  = ~i_low;
        dir_d   = DIR_DOWN;
        state_d = ST_DELAY;
      end else if (up_evt) begin
        up_d    = ~i_high;
        dir_d   = DIR_UP;
        state_d = ST_DELAY;
      end
    end else begin
      case (state_q)
        ST_DELAY: begin
          if (timer_q == TW'(REPEAT_DELAY - 1)) begin
            state_d = ST_REPEAT;
            timer_d = '0;
            up_d    = (dir_q == DIR_UP)   & ~i_high;
            down_d  = (dir_q == DIR_DOWN) & ~i_low;
          end else begin
            timer_d = timer_inc;
          end
        end
        ST_REPEAT: begin
          if (timer_q == TW'(REPEAT_PERIOD - 1)) begin
            timer_d = '0;
            up_d    = (dir_q == DIR_UP)   & ~i_high;
            down_d  = (dir_q == DIR_DOWN) & ~i_low;
          end else begin
            timer_d = timer_inc;
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      timer_q <= '0;
      load_q  <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      in_q    <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
      load_q  <= load_d;
      up_q    <= up_d;
      down_q  <= down_d;
      in_q    <= in_d;
    end
  end

  assign o_load = load_q;
  assign o_up   = up_q;
  assign o_down = down_q;
  assign o_in   = in_q;

endmodule

// File: tb/tb_up_down_cmd_ctrl.sv
// Directed bench: command front-end driving a behavioural 5-bit up/down counter.
module tb_up_down_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up, btn_down, btn_load;
  logic [4:0] sw;
  logic       high, low;
  logic       o_load, o_up, o_down;
  logic [4:0] o_in;
  logic [4:0] cnt;

  int errors = 0;
  int checks = 0;
  int n_up = 0, n_dn = 0, n_ld = 0;

  always #50 clk = ~clk;

  up_down_cmd_ctrl #(
    .DATA_WIDTH(5), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(2)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_btn_up(btn_up), .i_btn_down(btn_down), .i_btn_load(btn_load),
    .i_sw_value(sw), .i_high(high), .i_low(low),
    .o_load(o_load), .o_up(o_up), .o_down(o_down), .o_in(o_in)
  );

  // Counter stand-in: load has priority, registered count, flags decoded from it.
  always @(posedge clk) begin
    if (!rst_n)      cnt <= 5'd0;
    else if (o_load) cnt <= o_in;
    else if (o_up)   cnt <= cnt + 5'd1;
    else if (o_down) cnt <= cnt - 5'd1;
  end
  assign high = (cnt == 5'd31);
  assign low  = (cnt == 5'd0);

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic onehot_ok;
    @(posedge clk);
    @(negedge clk);
    onehot_ok = ($countones({o_load, o_up, o_down}) <= 1);
    checks++;
    assert (onehot_ok === 1'b1) else begin
      errors++;
      $error("FAIL onehot observed=%b expected=at-most-one", {o_load, o_up, o_down});
    end
    n_up += int'(o_up);
    n_dn += int'(o_down);
    n_ld += int'(o_load);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr();
    n_up = 0; n_dn = 0; n_ld = 0;
  endtask

  task automatic do_load(input logic [4:0] v);
    sw = v; btn_load = 1'b1; clr();
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 10) btn_load = 1'b0;
      if (i == 7) begin
        chk("load_pulse", int'(o_load), 1);
        chk("load_o_in", int'(o_in), int'(v));
      end
    end
    chk("load_count", n_ld, 1);
    chk("load_cnt", int'(cnt), int'(v));
  endtask

  initial begin
    rst_n = 1'b0; btn_up = 1'b1; btn_down = 1'b0; btn_load = 1'b0; sw = 5'd0;

    // Reset with up held: outputs quiet, then a fresh press after release
    ticks(3);
    chk("rst_outs", int'({o_load, o_up, o_down, o_in}), 0);
    rst_n = 1'b1; clr();
    ticks(6);
    chk("rst_no_early", n_up, 0);
    tick();
    chk("rst_up_at7", int'(o_up), 1);
    btn_up = 1'b0; clr();
    ticks(14);
    chk("rst_single", n_up, 0);
    chk("rst_cnt", int'(cnt), 1);

    // Bounce then stable high
    clr();
    btn_up = 1'b1; tick();
    btn_up = 1'b0; tick();
    btn_up = 1'b1; tick();
    btn_up = 1'b0; tick();
    btn_up = 1'b1;
    ticks(6);
    chk("bounce_quiet", n_up, 0);
    tick();
    chk("bounce_up_at7", int'(o_up), 1);
    btn_up = 1'b0;
    ticks(14);
    chk("bounce_single", n_up, 1);
    chk("bounce_cnt", int'(cnt), 2);

    do_load(5'd7);

    // Auto-repeat: pulses at 7, then 15 and every 2 up to 35; release after 30
    clr(); btn_up = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      tick();
      chk($sformatf("rep_t%0d", i), int'(o_up),
          int'(i == 7 || (i >= 15 && i <= 35 && (i % 2) == 1)));
      if (i == 30) btn_up = 1'b0;
    end
    chk("rep_total", n_up, 12);
    chk("rep_cnt", int'(cnt), 19);

    // Saturation at the top
    do_load(5'd30);
    clr(); btn_up = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (i == 15) chk("sat_up_suppressed", int'(o_up), 0);
      if (i == 30) btn_up = 1'b0;
    end
    chk("sat_up_count", n_up, 1);
    chk("sat_up_cnt", int'(cnt), 31);

    // Saturation at the bottom
    do_load(5'd1);
    clr(); btn_down = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (i == 7) chk("sat_dn_at7", int'(o_down), 1);
      if (i == 30) btn_down = 1'b0;
    end
    chk("sat_dn_count", n_dn, 1);
    chk("sat_dn_cnt", int'(cnt), 0);

    // Conflict, then load wins while both are still held
    do_load(5'd9);
    clr(); btn_up = 1'b1; btn_down = 1'b1;
    ticks(25);
    chk("conf_no_up", n_up, 0);
    chk("conf_no_dn", n_dn, 0);
    sw = 5'd12; btn_load = 1'b1;
    ticks(10);
    btn_load = 1'b0;
    ticks(15);
    chk("conf_load", n_ld, 1);
    chk("conf_o_in", int'(o_in), 12);
    chk("conf_still_no_ud", n_up + n_dn, 0);
    btn_up = 1'b0; btn_down = 1'b0;
    ticks(12);
    chk("conf_release_quiet", n_up + n_dn, 0);
    chk("conf_cnt", int'(cnt), 12);

    // Reset mid-press: restart, held button counts as a new press
    clr(); btn_up = 1'b1;
    ticks(10);
    chk("mid_first", n_up, 1);
    rst_n = 1'b0;
    ticks(2);
    chk("mid_rst_outs", int'({o_load, o_up, o_down, o_in}), 0);
    rst_n = 1'b1; clr();
    ticks(6);
    chk("mid_no_early", n_up, 0);
    tick();
    chk("mid_up_at7", int'(o_up), 1);
    btn_up = 1'b0;
    ticks(14);
    chk("mid_cnt", int'(cnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
